fft16_out_streamer: RTL and testbench
=====================================

# fft16_out_streamer

Reads the parallel result of the 16-point FFT core and serializes it into a stream of one complex bin per beat, with a valid/ready handshake. Each beat also carries a magnitude estimate. A frame is captured on each rising edge of the core's cycle-done flag. The block sits between `FFT16_top` and any downstream consumer (UART/packetizer, peak detector), which is why it has backpressure.

## Interface
Parameters:
- N, 16, word width of each re/im component (signed two's complement)
- Q, 8, fractional bits; informational only, all outputs keep Q fractional bits
- BINS, 16, bins per frame (fixed 16; index width 4)

Ports:
- i_clk  in  1  single clock; all logic rising-edge
- i_rst  in  1  synchronous, active-high reset
- i_bins_re  in  BINS*N  packed real parts; bin k at [k*N +: N]
- i_bins_im  in  BINS*N  packed imaginary parts, same packing
- i_FFT_cycle_done  in  1  core result-ready flag (level; may stay high several cycles)
- i_ready  in  1  downstream ready
- o_valid  out  1  current beat valid
- o_re  out  N  real part of current bin
- o_im  out  N  imaginary part of current bin
- o_mag  out  N+1  unsigned magnitude estimate of current bin
- o_bin_idx  out  4  index of current bin, 0..15
- o_last  out  1  high with bin 15
- o_busy  out  1  frame held / streaming
- o_overrun  out  1  one-cycle pulse: a frame was dropped

## Operation
- FSM with 2 states.
  - IDLE: o_valid=0, o_busy=0.
  - STREAM: o_valid=1, o_busy=1.
- Capture event: i_FFT_cycle_done=1 at this edge and =0 at the previous edge (internal prev register).
- IDLE + capture event:
  - latch all 32 words into the frame buffer;
  - index <= 0;
  - go to STREAM.
- STREAM:
  - o_re/o_im = buffer[index]; o_bin_idx = index; o_last = (index==15).
  - A transfer happens on an edge where o_valid & i_ready.
  - Transfer on bin <15: index+1.
  - Transfer on bin 15: go to IDLE, unless a capture event occurs on the same edge. In that case capture the new frame, set index <= 0, and stay in STREAM (back-to-back, no bubble).
- Capture event in STREAM with no final transfer on that edge:
  - new frame ignored;
  - o_overrun pulses high for the following cycle;
  - current frame continues unaffected.
- Backpressure: while o_valid & !i_ready, all outputs hold stable. o_valid never deasserts before the beat transfers.
- Magnitude: a=|re|, b=|im| (unsigned N bits; |−2^(N−1)| = 2^(N−1), no saturation). o_mag = max(a,b) + (min(a,b)>>1), unsigned N+1 bits, no overflow possible.

## Timing
- Reset values: o_valid=0, o_re=0, o_im=0, o_mag=0, o_bin_idx=0, o_last=0, o_busy=0, o_overrun=0. Frame buffer cleared; state IDLE.
- The edge-detect prev register resets to 1. A done flag held high through reset does not trigger a capture; it must fall and rise again.
- Latency: capture edge t → o_valid=1 with bin 0 during cycle t+1.
- Throughput: 16 beats in 16 cycles with i_ready held high. Next frame is accepted on the bin-15 transfer edge.
- o_re/o_im/o_mag/o_last are combinational from registered state only (buffer, index). No input-to-output combinational path exists except through registers.
- Reset asserted mid-stream: the frame is abandoned; all outputs go to reset values on that edge.
- o_overrun is never high on the same cycle as a capture. It fires at most once per ignored rising edge.

## Structure
- Shared package `fft16_pkg`:
  - N, Q, BINS defaults;
  - BIN_IDX_W=4;
  - state enum {ST_IDLE, ST_STREAM}.
  - Reused by `FFT16_top` integration and by a future input-side collector.
- Sub-module `fft16_mag_est`: combinational abs/max/min/shift-add, N in, N+1 out. It is instantiated once on the muxed bin.

## Test plan
- Single frame, i_ready=1:
  - Stimulus: bin0=(0x016A,0x00C9), bin1=(0xFE96,0x00C9), bin3=(0x016A,0xFF37), bin7=(0xFE96,0xFF37), others 0.
  - Response: 16 beats on consecutive cycles starting 1 cycle after the done rise.
  - bins 0/1/3/7: o_mag=462 (0x1CE); others 0.
  - o_last only on beat 15.
- Backpressure: i_ready toggled 1,0,0,1 pattern → o_re/o_im/o_mag/o_bin_idx stable across stalled cycles. Exactly 16 transfers in order 0..15.
- Overrun: second done rise while streaming bin 5.
  - o_overrun high for 1 cycle.
  - Remaining bins are from the first frame.
  - o_valid drops after bin 15.
- Back-to-back: done rises on the same edge as the bin-15 transfer → next cycle o_valid=1, o_bin_idx=0, new frame data, o_overrun=0.
- Extremes: bin2=(0x8000,0x0000) → o_mag=32768. bin4=(0x7FFF,0x8000) → o_mag=32768+16383=49151.
- Reset mid-stream at bin 8, with done held high through reset:
  - all outputs are 0 after reset;
  - no capture until done falls and rises again.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared constants and state encoding for the FFT16 output streamer and
// the neighbouring blocks around FFT16_top.
package fft16_pkg;

  localparam int N         = 16;
  localparam int Q         = 8;
  localparam int BINS      = 16;
  localparam int BIN_IDX_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/fft16_mag_est.sv
// Magnitude estimate max(|re|,|im|) + min(|re|,|im|)/2; purely combinational.
// Output is one bit wider than the inputs, so neither abs() nor the sum can overflow.
module fft16_mag_est #(
  parameter int N = fft16_pkg::N
) (
  input  logic [N-1:0] re_i,
  input  logic [N-1:0] im_i,
  output logic [N:0]   mag_o
);

  logic [N-1:0] abs_re;
  logic [N-1:0] abs_im;
  logic [N-1:0] mx;
  logic [N-1:0] mn;

  // Two's-complement negate taken as unsigned: the most negative value maps to 2^(N-1).
  assign abs_re = re_i[N-1] ? (~re_i + N'(1)) : re_i;
  assign abs_im = im_i[N-1] ? (~im_i + N'(1)) : im_i;

  assign mx = (abs_re >= abs_im) ? abs_re : abs_im;
  assign mn = (abs_re >= abs_im) ? abs_im : abs_re;

  assign mag_o = {1'b0, mx} + ({1'b0, mn} >> 1);

endmodule

// File: rtl/fft16_out_streamer.sv
// Captures a 16-bin FFT frame on a done-flag rise and streams one bin per beat; bin 0 one cycle after capture.
// Beats hold under !i_ready; a rise while streaming drops that frame and pulses o_overrun, except on the bin-15 transfer edge.
module fft16_out_streamer #(
  parameter int N    = fft16_pkg::N,
  parameter int Q    = fft16_pkg::Q,
  parameter int BINS = fft16_pkg::BINS
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [BINS*N-1:0]              i_bins_re,
  input  logic [BINS*N-1:0]              i_bins_im,
  input  logic                           i_FFT_cycle_done,
  input  logic                           i_ready,
  output logic                           o_valid,
  output logic [N-1:0]                   o_re,
  output logic [N-1:0]                   o_im,
  output logic [N:0]                     o_mag,
  output logic [fft16_pkg::BIN_IDX_W-1:0] o_bin_idx,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_overrun
);

  import fft16_pkg::*;

  localparam int IW = BIN_IDX_W;

  if (BINS != 16 || Q >= N) begin : g_param_chk
    $error("fft16_out_streamer: BINS must be 16 and Q must be below N");
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BINS*N-1:0] frm_re_q, frm_re_d;
  logic [BINS*N-1:0] frm_im_q, frm_im_d;
  logic              done_prev_q;
  logic              overrun_q, overrun_d;

  logic              capture;
  logic              streaming;
  logic              xfer;
  logic              last_bin;
  logic              load;
  logic [N-1:0]      bin_re;
  logic [N-1:0]      bin_im;
  logic [N:0]        bin_mag;

  assign capture   = i_FFT_cycle_done & ~done_prev_q;
  assign streaming = (state_q == ST_STREAM);
  assign xfer      = streaming & i_ready;
  assign last_bin  = (idx_q == IW'(BINS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer && last_bin) begin
          // Final beat leaves the buffer free, so a rise on this edge is a clean back-to-back capture.
          idx_d = '0;
          if (capture) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IW'(1);
          end
          overrun_d = capture;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign frm_re_d = load ? i_bins_re : frm_re_q;
  assign frm_im_d = load ? i_bins_im : frm_im_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      frm_re_q    <= '0;
      frm_im_q    <= '0;
      done_prev_q <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frm_re_q    <= frm_re_d;
      frm_im_q    <= frm_im_d;
      done_prev_q <= i_FFT_cycle_done;
      overrun_q   <= overrun_d;
    end
  end

  assign bin_re = frm_re_q[idx_q*N +: N];
  assign bin_im = frm_im_q[idx_q*N +: N];

  fft16_mag_est #(
    .N (N)
  ) u_mag (
    .re_i  (bin_re),
    .im_i  (bin_im),
    .mag_o (bin_mag)
  );

  assign o_valid   = streaming;
  assign o_busy    = streaming;
  assign o_re      = streaming ? bin_re  : '0;
  assign o_im      = streaming ? bin_im  : '0;
  assign o_mag     = streaming ? bin_mag : '0;
  assign o_last    = streaming & last_bin;
  assign o_bin_idx = idx_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_fft16_out_streamer.sv
// Directed bench for fft16_out_streamer: scoreboard of expected beats, checked on the negative clock edge.
module tb_fft16_out_streamer;

  localparam int N    = 16;
  localparam int BINS = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [BINS*N-1:0] i_bins_re;
  logic [BINS*N-1:0] i_bins_im;
  logic              i_FFT_cycle_done;
  logic              i_ready;
  logic              o_valid;
  logic [N-1:0]      o_re;
  logic [N-1:0]      o_im;
  logic [N:0]        o_mag;
  logic [3:0]        o_bin_idx;
  logic              o_last;
  logic              o_busy;
  logic              o_overrun;

  fft16_out_streamer dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_bins_re        (i_bins_re),
    .i_bins_im        (i_bins_im),
    .i_FFT_cycle_done (i_FFT_cycle_done),
    .i_ready          (i_ready),
    .o_valid          (o_valid),
    .o_re             (o_re),
    .o_im             (o_im),
    .o_mag            (o_mag),
    .o_bin_idx        (o_bin_idx),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_overrun        (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [16:0] mag;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [15:0] fr_re[16];
  logic [15:0] fr_im[16];
  int          n_cmp   = 0;
  int          n_err   = 0;
  int          n_pop   = 0;
  int          ovr_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] s_re, s_im;
  logic [16:0] s_mag;
  logic [3:0]  s_idx;

  function automatic logic [16:0] mag_model(logic [15:0] re, logic [15:0] im);
    int a, b, mx, mn;
    a = $signed(re);
    b = $signed(im);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return 17'(mx + mn / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) begin
      fr_re[k] = 16'($urandom);
      fr_im[k] = 16'($urandom);
    end
  endtask

  // Drive the frame onto the core outputs and queue the 16 beats it should produce.
  task automatic load_frame();
    for (int k = 0; k < 16; k++) begin
      i_bins_re[k*N +: N] = fr_re[k];
      i_bins_im[k*N +: N] = fr_im[k];
      sb.push_back('{re: fr_re[k], im: fr_im[k], mag: mag_model(fr_re[k], fr_im[k]),
                     idx: 4'(k), last: (k == 15)});
    end
  endtask

  task automatic step(input logic rdy, input logic done);
    beat_t e;
    @(negedge i_clk);
    if (stall_prev) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_re", 32'(o_re), 32'(s_re));
      chk("hold_im", 32'(o_im), 32'(s_im));
      chk("hold_mag", 32'(o_mag), 32'(s_mag));
      chk("hold_idx", 32'(o_bin_idx), 32'(s_idx));
    end
    if (o_overrun) ovr_cnt++;
    if (o_valid && rdy) begin
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_re", 32'(o_re), 32'(e.re));
        chk("beat_im", 32'(o_im), 32'(e.im));
        chk("beat_mag", 32'(o_mag), 32'(e.mag));
        chk("beat_idx", 32'(o_bin_idx), 32'(e.idx));
        chk("beat_last", 32'(o_last), 32'(e.last));
        chk("beat_busy", 32'(o_busy), 32'd1);
        n_pop++;
      end
    end
    stall_prev = o_valid && !rdy;
    s_re  = o_re;
    s_im  = o_im;
    s_mag = o_mag;
    s_idx = o_bin_idx;
    i_ready          = rdy;
    i_FFT_cycle_done = done;
  endtask

  task automatic drain(input int max_cyc, input logic [3:0] pat);
    int k;
    k = 0;
    while (sb.size() != 0 && k < max_cyc) begin
      step(pat[k % 4], 1'b0);
      k++;
    end
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    step(1'b1, 1'b0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_re"}, 32'(o_re), 32'd0);
    chk({tag, "_im"}, 32'(o_im), 32'd0);
    chk({tag, "_mag"}, 32'(o_mag), 32'd0);
    chk({tag, "_idx"}, 32'(o_bin_idx), 32'd0);
    chk({tag, "_last"}, 32'(o_last), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_ready = 1'b0;
    i_FFT_cycle_done = 1'b0;
    i_bins_re = '0;
    i_bins_im = '0;
    repeat (3) @(negedge i_clk);
    chk_reset_outputs("reset");
    i_rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Single frame, ready held high: 16 consecutive beats from the cycle after the rise.
    clear_frame();
    fr_re[0] = 16'h016A; fr_im[0] = 16'h00C9;
    fr_re[1] = 16'hFE96; fr_im[1] = 16'h00C9;
    fr_re[3] = 16'h016A; fr_im[3] = 16'hFF37;
    fr_re[7] = 16'hFE96; fr_im[7] = 16'hFF37;
    load_frame();
    n_pop = 0;
    ovr_cnt = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i < 2);
      if (i == 0) chk("t1_mag_bin0", 32'(o_mag), 32'd462);
      if (i == 7) chk("t1_mag_bin7", 32'(o_mag), 32'd462);
      if (i == 15) chk("t1_last", 32'(o_last), 32'd1);
    end
    chk("t1_pops", 32'(n_pop), 32'd16);
    chk_idle("t1_end");

    // Backpressure with ready pattern 1,0,0,1.
    rand_frame();
    load_frame();
    n_pop = 0;
    step(1'b1, 1'b1);
    drain(100, 4'b1001);
    chk("t2_pops", 32'(n_pop), 32'd16);
    chk_idle("t2_end");

    // Overrun: second rise while bin 5 is on the output.
    rand_frame();
    load_frame();
    n_pop = 0;
    ovr_cnt = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      i_bins_re[k*N +: N] = 16'($urandom);
      i_bins_im[k*N +: N] = 16'($urandom);
    end
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("t3_overrun_hi", 32'(o_overrun), 32'd1);
    step(1'b1, 1'b0);
    chk("t3_overrun_lo", 32'(o_overrun), 32'd0);
    drain(40, 4'b1111);
    chk("t3_overrun_cnt", 32'(ovr_cnt), 32'd1);
    chk("t3_pops", 32'(n_pop), 32'd16);
    chk_idle("t3_end");

    // Back-to-back capture on the bin-15 transfer edge; first frame carries the extremes.
    rand_frame();
    fr_re[2] = 16'h8000; fr_im[2] = 16'h0000;
    fr_re[4] = 16'h7FFF; fr_im[4] = 16'h8000;
    load_frame();
    n_pop = 0;
    ovr_cnt = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0);
      if (i == 2) chk("t4_mag_neg_full", 32'(o_mag), 32'd32768);
      if (i == 4) chk("t4_mag_mixed", 32'(o_mag), 32'd49151);
    end
    rand_frame();
    load_frame();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("t4_b2b_valid", 32'(o_valid), 32'd1);
    chk("t4_b2b_idx", 32'(o_bin_idx), 32'd0);
    chk("t4_b2b_overrun", 32'(o_overrun), 32'd0);
    drain(40, 4'b1111);
    chk("t4_pops", 32'(n_pop), 32'd32);
    chk("t4_overrun_cnt", 32'(ovr_cnt), 32'd0);
    chk_idle("t4_end");

    // Reset at bin 8 with done held high: no capture until done falls and rises again.
    rand_frame();
    load_frame();
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    @(negedge i_clk);
    chk("t5_at_bin8", 32'(o_bin_idx), 32'd8);
    i_rst = 1'b1;
    sb.delete();
    stall_prev = 1'b0;
    @(negedge i_clk);
    chk_reset_outputs("t5_reset");
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      chk("t5_no_capture", 32'(o_valid), 32'd0);
    end
    step(1'b1, 1'b0);
    rand_frame();
    load_frame();
    n_pop = 0;
    step(1'b1, 1'b1);
    drain(40, 4'b1111);
    chk("t5_pops", 32'(n_pop), 32'd16);
    chk_idle("t5_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
